fnd_scan_driver: RTL and testbench

- Time-multiplexed 4-digit FND scan controller that sits around the FND digit coder.
- Latches a 14-bit display value and presents it to the coder with a stable frame-aligned update.
- Drives the coder's 2-bit digit select and takes the coder's 4-bit BCD result back.
- Produces the active-low common-anode digit enables and segment font, with inter-digit blanking to suppress ghosting.

---
 rtl/fnd_scan_driver.sv | 117 +++++++++++
 tb/tb_fnd_scan_driver.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/fnd_scan_driver.sv
// Four-digit multiplexed FND scan controller around an external BCD digit coder.
// Define FND_LZB_EN to enable leading-zero blanking of the upper digits.
module fnd_scan_driver #(
    parameter int unsigned CLK_HZ       = 100000000,
    parameter int unsigned SCAN_HZ      = 4000,
    parameter int unsigned BLANK_CYCLES = 1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_en,
    input  logic [13:0] i_value,
    input  logic        i_valueValid,
    input  logic [3:0]  i_bcd,
    input  logic [3:0]  i_dpMask,
    output logic [1:0]  o_fndDigit,
    output logic [13:0] o_fndData,
    output logic [3:0]  o_fndCom,
    output logic [7:0]  o_fndFont,
    output logic        o_overflow
);

    localparam int unsigned   P        = CLK_HZ / SCAN_HZ;
    localparam int unsigned   CW       = (P > 1) ? $clog2(P) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(P - 1);
    localparam logic [CW-1:0] CNT_CAP  = CW'(BLANK_CYCLES - 1);
    localparam logic [13:0]   MAX_VAL  = 14'd9999;

    typedef enum logic {BLANK, SHOW} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [13:0]   shadow;
    logic [6:0]    seg;
    logic          digitLit;
    logic [3:0]    showCom;
    logic [7:0]    showFont;

    always_comb begin
        unique case (i_bcd)
            4'd0:    seg = 7'h40;
            4'd1:    seg = 7'h79;
            4'd2:    seg = 7'h24;
            4'd3:    seg = 7'h30;
            4'd4:    seg = 7'h19;
            4'd5:    seg = 7'h12;
            4'd6:    seg = 7'h02;
            4'd7:    seg = 7'h78;
            4'd8:    seg = 7'h00;
            4'd9:    seg = 7'h10;
            default: seg = 7'h3F;
        endcase
    end

`ifdef FND_LZB_EN
    always_comb begin
        unique case (o_fndDigit)
            2'd0:    digitLit = 1'b1;
            2'd1:    digitLit = (o_fndData >= 14'd10);
            2'd2:    digitLit = (o_fndData >= 14'd100);
            default: digitLit = (o_fndData >= 14'd1000);
        endcase
    end
`else
    assign digitLit = 1'b1;
`endif

    always_comb begin
        showCom  = '1;
        showFont = '1;
        if (digitLit) begin
            showCom  = ~(4'b0001 << o_fndDigit);
            showFont = {~i_dpMask[o_fndDigit], seg};
        end
    end

    // Font is captured one cycle before SHOW so the coder has seen the new digit select for a full BLANK phase.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt        <= '0;
            state      <= BLANK;
            o_fndDigit <= '0;
            o_fndData  <= '0;
            shadow     <= '0;
            o_overflow <= 1'b0;
            o_fndCom   <= '1;
            o_fndFont  <= '1;
        end else begin
            if (i_valueValid) begin
                shadow     <= (i_value > MAX_VAL) ? MAX_VAL : i_value;
                o_overflow <= (i_value > MAX_VAL);
            end
            if (!i_en) begin
                cnt      <= '0;
                state    <= BLANK;
                o_fndCom <= '1;
                o_fndFont <= '1;
            end else if (cnt == CNT_LAST) begin
                cnt        <= '0;
                state      <= BLANK;
                o_fndDigit <= o_fndDigit + 2'd1;
                o_fndCom   <= '1;
                o_fndFont  <= '1;
                if (o_fndDigit == 2'd3) begin
                    o_fndData <= shadow;
                end
            end else begin
                cnt <= cnt + CW'(1);
                if (state == BLANK && cnt == CNT_CAP) begin
                    state     <= SHOW;
                    o_fndCom  <= showCom;
                    o_fndFont <= showFont;
                end
            end
        end
    end

endmodule

// File: tb/tb_fnd_scan_driver.sv
// Randomized bench for fnd_scan_driver with a cycle-level behavioural display model.
module tb_fnd_scan_driver;

    localparam int P     = 10;
    localparam int BLANK = 2;

    logic        clk = 1'b0;
    logic        rstN;
    logic        en;
    logic [13:0] value;
    logic        valid;
    logic [3:0]  bcd;
    logic [3:0]  dpMask;
    logic [1:0]  fndDigit;
    logic [13:0] fndData;
    logic [3:0]  fndCom;
    logic [7:0]  fndFont;
    logic        overflow;

    logic        bcdForce;
    logic [3:0]  bcdVal;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // model state: time since last (re)start and the digit it started on
    int          t;
    int          start;
    logic [13:0] mShadow;
    logic [13:0] mData;
    logic        mOvf;
    logic [3:0]  mCom;
    logic [7:0]  mFont;

    logic [7:0] fontLut [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
    int pow10 [4] = '{1, 10, 100, 1000};

    fnd_scan_driver #(.CLK_HZ(1000), .SCAN_HZ(100), .BLANK_CYCLES(2)) dut (
        .clk(clk), .reset(rstN), .i_en(en), .i_value(value), .i_valueValid(valid),
        .i_bcd(bcd), .i_dpMask(dpMask), .o_fndDigit(fndDigit), .o_fndData(fndData),
        .o_fndCom(fndCom), .o_fndFont(fndFont), .o_overflow(overflow)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] coderBcd(input logic [13:0] d, input logic [1:0] g);
        int v;
        v = int'(d);
        for (int i = 0; i < int'(g); i++) v = v / 10;
        return 4'(v % 10);
    endfunction

    always_comb bcd = bcdForce ? bcdVal : coderBcd(fndData, fndDigit);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h cycle=%0d", name, act, exp, cyc);
        end
    endtask

    task automatic modelEdge();
        int ph, dg;
        logic [13:0] oldShadow;
        logic [3:0]  b;
        logic        lit;
        if (!rstN) begin
            t = 0; start = 0; mShadow = '0; mData = '0; mOvf = 1'b0;
            mCom = 4'hF; mFont = 8'hFF;
            return;
        end
        oldShadow = mShadow;
        if (valid) begin
            mShadow = (value > 14'd9999) ? 14'd9999 : value;
            mOvf    = (value > 14'd9999);
        end
        dg = (start + t / P) % 4;
        ph = t % P;
        if (!en) begin
            start = dg; t = 0; mCom = 4'hF; mFont = 8'hFF;
        end else begin
            if (ph == BLANK - 1) begin
                b = bcdForce ? bcdVal : coderBcd(mData, 2'(dg));
`ifdef FND_LZB_EN
                lit = (dg == 0) || (int'(mData) >= pow10[dg]);
`else
                lit = 1'b1;
`endif
                if (lit) begin
                    mCom  = ~(4'b0001 << dg);
                    mFont = {~dpMask[dg], (b > 4'd9) ? 7'h3F : fontLut[b][6:0]};
                end else begin
                    mCom = 4'hF; mFont = 8'hFF;
                end
            end else if (ph == P - 1) begin
                mCom = 4'hF; mFont = 8'hFF;
                if (dg == 3) mData = oldShadow;
            end
            t++;
        end
    endtask

    task automatic compareAll();
        check("digit", 32'(fndDigit), 32'((start + t / P) % 4));
        check("data", 32'(fndData), 32'(mData));
        check("com", 32'(fndCom), 32'(mCom));
        check("font", 32'(fndFont), 32'(mFont));
        check("overflow", 32'(overflow), 32'(mOvf));
    endtask

    task automatic step();
        @(posedge clk);
        modelEdge();
        cyc++;
        @(negedge clk);
        compareAll();
    endtask

    task automatic runTo(input int target);
        while (cyc < target) step();
    endtask

    initial begin
        int r;
        rstN = 1'b0; en = 1'b0; value = '0; valid = 1'b0; dpMask = '0;
        bcdForce = 1'b0; bcdVal = '0;
        t = 0; start = 0; mShadow = '0; mData = '0; mOvf = 1'b0; mCom = 4'hF; mFont = 8'hFF;
        @(negedge clk);
        repeat (3) step();
        check("rst_com", 32'(fndCom), 32'h F);
        check("rst_font", 32'(fndFont), 32'h FF);
        check("rst_digit", 32'(fndDigit), 0);
        check("rst_data", 32'(fndData), 0);
        check("rst_ovf", 32'(overflow), 0);

        rstN = 1'b1; en = 1'b1; cyc = 0;
        step();
        check("c1_com", 32'(fndCom), 32'h F);
        check("c1_font", 32'(fndFont), 32'h FF);
        step();
        check("c2_com", 32'(fndCom), 32'h E);
        check("c2_font", 32'(fndFont), 32'h C0);
        runTo(9);  check("c9_digit", 32'(fndDigit), 0);
        runTo(10); check("c10_digit", 32'(fndDigit), 1);
        runTo(20); check("c20_digit", 32'(fndDigit), 2);
        runTo(30); check("c30_digit", 32'(fndDigit), 3);
        runTo(40); check("c40_digit", 32'(fndDigit), 0);

        runTo(45); value = 14'd1234; valid = 1'b1; step(); valid = 1'b0;
        runTo(79); check("data_pre", 32'(fndData), 0);
        runTo(80); check("data_post", 32'(fndData), 1234);
        runTo(82);  check("d0_font", 32'(fndFont), 32'h99); check("d0_com", 32'(fndCom), 32'hE);
        runTo(92);  check("d1_font", 32'(fndFont), 32'hB0); check("d1_com", 32'(fndCom), 32'hD);
        runTo(102); check("d2_font", 32'(fndFont), 32'hA4); check("d2_com", 32'(fndCom), 32'hB);
        runTo(112); check("d3_font", 32'(fndFont), 32'hF9); check("d3_com", 32'(fndCom), 32'h7);

        dpMask = 4'b0100;
        runTo(122); check("dp_d0", 32'(fndFont), 32'h99);
        runTo(142); check("dp_d2", 32'(fndFont), 32'h24);
        runTo(152); check("dp_d3", 32'(fndFont), 32'hF9);
        dpMask = 4'b0000;

        runTo(155); value = 14'd12000; valid = 1'b1; step(); valid = 1'b0;
        check("ovf_set", 32'(overflow), 1);
        runTo(160); check("ovf_data", 32'(fndData), 9999);
        runTo(162); check("ovf_font", 32'(fndFont), 32'h90);
        runTo(164); value = 14'd5; valid = 1'b1; step(); valid = 1'b0;
        check("ovf_clr", 32'(overflow), 0);

        runTo(174);
        check("en_pre_com", 32'(fndCom), 32'hD);
        en = 1'b0; step();
        check("en_dark_com", 32'(fndCom), 32'hF);
        check("en_dark_font", 32'(fndFont), 32'hFF);
        check("en_hold_digit", 32'(fndDigit), 1);
        repeat (4) step();
        en = 1'b1; step();
        check("en_blank_com", 32'(fndCom), 32'hF);
        step();
        check("en_resume_com", 32'(fndCom), 32'hD);
        check("en_resume_font", 32'(fndFont), 32'h90);

        bcdForce = 1'b1; bcdVal = 4'd12;
        repeat (P) step();
        check("dash_font", 32'(fndFont), 32'hBF);
        check("dash_com", 32'(fndCom), 32'hB);
        bcdForce = 1'b0;

        value = 14'd777; valid = 1'b1; step(); valid = 1'b0;
        rstN = 1'b0; step();
        check("rmid_com", 32'(fndCom), 32'hF);
        check("rmid_font", 32'(fndFont), 32'hFF);
        check("rmid_digit", 32'(fndDigit), 0);
        check("rmid_data", 32'(fndData), 0);
        rstN = 1'b1; cyc = 0;
        runTo(45); check("rmid_discard", 32'(fndData), 0);

`ifdef FND_LZB_EN
        value = 14'd7; valid = 1'b1; step(); valid = 1'b0;
        runTo(80);
        repeat (40) begin
            step();
            check("lzb7_com", 32'(fndCom == 4'hE || fndCom == 4'hF), 1);
        end
        value = 14'd40; valid = 1'b1; step(); valid = 1'b0;
        runTo(160);
        repeat (40) begin
            step();
            check("lzb40_com", 32'(fndCom == 4'hB || fndCom == 4'h7), 0);
        end
`endif

        repeat (2500) begin
            r = $urandom_range(0, 3);
            case (r)
                0: value = 14'($urandom_range(0, 16383));
                1: value = 14'($urandom_range(0, 9));
                2: value = 14'($urandom_range(0, 99));
                default: value = 14'($urandom_range(0, 9999));
            endcase
            valid = ($urandom_range(0, 19) == 0);
            en    = ($urandom_range(0, 40) != 0);
            rstN  = ($urandom_range(0, 700) != 0);
            if ($urandom_range(0, 29) == 0) dpMask = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 199) == 0) begin
                bcdForce = ~bcdForce;
                bcdVal   = 4'($urandom_range(10, 15));
            end
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
